// File: rtl/ram_sp_clr.sv
// Single-port RAM with a self-clearing fill engine.
// After reset or a clr request the whole array is overwritten with CLR_VAL,
// one word per cycle, while busy is high. Reads and writes both return the
// word at addr through a registered pipeline of RD_LAT stages (1 or 2).
// RW_MODE selects what a write returns: 0 = old contents, 1 = new data.
module ram_sp_clr #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 6,
  parameter int                RD_LAT  = 1,
  parameter int                RW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Read pipeline; stage 0 is fed straight from the array.
  logic [DATA_W-1:0]   pipe_q_reg [RD_LAT];
  logic                pipe_v_reg [RD_LAT];

  logic                acc;
  logic                fill_we;
  logic [DATA_W-1:0]   rd_word;

  // An access is taken only in READY and only when no clear is requested.
  assign acc     = en && !clr && (state_reg == READY);
  assign fill_we = (state_reg == CLEAR);
  assign busy    = (state_reg == CLEAR);

  // Write-first forwards the incoming data; read-first returns the old word.
  assign rd_word = (RW_MODE == 1 && wr) ? data : mem[addr];

  // Clear/ready sequencer: walks cnt over every address, restarts on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (clr) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= READY;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (clr) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
          end
        end
      endcase
    end
  end

  // Memory array: fill engine has priority, otherwise accepted writes land.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[cnt_reg] <= CLR_VAL;
    end else if (acc && wr) begin
      mem[addr] <= data;
    end
  end

  // Read pipeline: data registers only load on a valid so q holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v_reg[i] <= 1'b0;
        pipe_q_reg[i] <= '0;
      end
    end else begin
      pipe_v_reg[0] <= acc;
      if (acc) begin
        pipe_q_reg[0] <= rd_word;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_reg[i] <= pipe_v_reg[i-1];
        if (pipe_v_reg[i-1]) begin
          pipe_q_reg[i] <= pipe_q_reg[i-1];
        end
      end
    end
  end

  assign q       = pipe_q_reg[RD_LAT-1];
  assign q_valid = pipe_v_reg[RD_LAT-1];

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr: two instances share one stimulus stream.
//   dut_a : defaults (RD_LAT=1, read-first, clear to 0x00)
//   dut_b : RD_LAT=2, write-first, clear to 0xFF
// Expected read data is queued with its due cycle when an access is driven
// and compared when that cycle arrives; q_valid must be low otherwise.
module tb_ram_sp_clr;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       en;
  logic       wr;
  logic [5:0] addr;
  logic [7:0] data;

  logic [7:0] q_a, q_b;
  logic       q_valid_a, q_valid_b;
  logic       busy_a, busy_b;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [64];

  ram_sp_clr dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .wr     (wr),
    .addr   (addr),
    .data   (data),
    .q      (q_a),
    .q_valid(q_valid_a),
    .busy   (busy_a)
  );

  ram_sp_clr #(
    .RD_LAT (2),
    .RW_MODE(1),
    .CLR_VAL(8'hFF)
  ) dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .en     (en),
    .wr     (wr),
    .addr   (addr),
    .data   (data),
    .q      (q_b),
    .q_valid(q_valid_b),
    .busy   (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor for both instances.
  always @(negedge clk) begin
    if (sb_a.size() > 0 && sb_a[0].due == cyc) begin
      check_value("qv_a", 32'(q_valid_a), 32'd1);
      check_value("q_a", 32'(q_a), 32'(sb_a[0].val));
      void'(sb_a.pop_front());
    end else begin
      check_value("idle_qv_a", 32'(q_valid_a), 32'd0);
    end
    if (sb_b.size() > 0 && sb_b[0].due == cyc) begin
      check_value("qv_b", 32'(q_valid_b), 32'd1);
      check_value("q_b", 32'(q_b), 32'(sb_b[0].val));
      void'(sb_b.pop_front());
    end else begin
      check_value("idle_qv_b", 32'(q_valid_b), 32'd0);
    end
  end

  task automatic fill_models();
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'hFF;
    end
  endtask

  task automatic drive_idle();
    @(posedge clk);
    #1;
    en  = 1'b0;
    wr  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_access(input logic w, input logic [5:0] a, input logic [7:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    en   = 1'b1;
    wr   = w;
    addr = a;
    data = d;
    clr  = 1'b0;
    e.due = cyc + 1;
    e.val = mem_a[a];
    sb_a.push_back(e);
    e.due = cyc + 2;
    e.val = w ? d : mem_b[a];
    sb_b.push_back(e);
    if (w) begin
      mem_a[a] = d;
      mem_b[a] = d;
    end
    $display("txn %s addr=%0d data=%02h", w ? "wr" : "rd", a, d);
  endtask

  // Counts negedges with busy high on each instance until both are idle.
  task automatic wait_ready(input string tag);
    int na = 0;
    int nb = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_a) na++;
      if (busy_b) nb++;
      if (!busy_a && !busy_b && (na > 0 || nb > 0)) break;
    end
    check_value({tag, "_busy_a"}, 32'(na), 32'd64);
    check_value({tag, "_busy_b"}, 32'(nb), 32'd64);
  endtask

  // One-cycle clr pulse, optionally with a write to addr 3 that must be dropped.
  task automatic clr_pulse(input logic with_acc);
    @(posedge clk);
    #1;
    clr  = 1'b1;
    en   = with_acc;
    wr   = 1'b1;
    addr = 6'd3;
    data = 8'h77;
    $display("txn clr with_acc=%0d", with_acc);
    @(posedge clk);
    #1;
    clr = 1'b0;
    en  = 1'b0;
    fill_models();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_q_a"}, 32'(q_a), 32'd0);
    check_value({tag, "_qv_a"}, 32'(q_valid_a), 32'd0);
    check_value({tag, "_busy_a"}, 32'(busy_a), 32'd1);
    check_value({tag, "_q_b"}, 32'(q_b), 32'd0);
    check_value({tag, "_qv_b"}, 32'(q_valid_b), 32'd0);
    check_value({tag, "_busy_b"}, 32'(busy_b), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    clr   = 1'b0;
    en    = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    data  = '0;
    fill_models();
    #2;
    rst_n = 1'b0;

    // Reset state, then a full-length initial fill.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    wait_ready("init");

    // Every address reads back the clear value.
    for (int i = 0; i < 64; i++) do_access(1'b0, 6'(i), 8'h00);
    drive_idle();
    repeat (3) drive_idle();

    // Contiguous writes of addr+1, then contiguous readback.
    for (int i = 0; i < 64; i++) do_access(1'b1, 6'(i), 8'(i + 1));
    for (int i = 0; i < 64; i++) do_access(1'b0, 6'(i), 8'h00);
    drive_idle();

    // Read-first vs write-first on a write over 0x55.
    do_access(1'b1, 6'd5, 8'h55);
    do_access(1'b1, 6'd5, 8'hAA);
    do_access(1'b0, 6'd5, 8'h00);
    drive_idle();

    // Load 1..3 then back-to-back reads.
    do_access(1'b1, 6'd1, 8'h11);
    do_access(1'b1, 6'd2, 8'h22);
    do_access(1'b1, 6'd3, 8'h33);
    do_access(1'b0, 6'd1, 8'h00);
    do_access(1'b0, 6'd2, 8'h00);
    do_access(1'b0, 6'd3, 8'h00);

    // A read in flight when clr arrives completes with pre-clear data;
    // the write presented alongside clr is dropped.
    do_access(1'b0, 6'd3, 8'h00);
    clr_pulse(1'b1);
    wait_ready("clr");
    do_access(1'b0, 6'd3, 8'h00);
    do_access(1'b0, 6'd5, 8'h00);
    drive_idle();

    // Random traffic with idle gaps.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) drive_idle();
      else do_access(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)));
    end
    drive_idle();
    repeat (3) drive_idle();

    // Reset while the clear counter sits at 20.
    do_access(1'b1, 6'd9, 8'h99);
    do_access(1'b0, 6'd9, 8'h00);
    drive_idle();
    repeat (2) drive_idle();
    clr_pulse(1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_a.delete();
    sb_b.delete();
    #1;
    check_reset_outputs("midclr");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("midclr");
    fill_models();

    // Reset with a read in flight: no stale pulse after release.
    do_access(1'b1, 6'd9, 8'h99);
    do_access(1'b0, 6'd9, 8'h00);
    @(posedge clk);
    #1;
    en    = 1'b0;
    rst_n = 1'b0;
    sb_a.delete();
    sb_b.delete();
    #1;
    check_reset_outputs("midrd");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("midrd");
    fill_models();

    do_access(1'b0, 6'd9, 8'h00);
    do_access(1'b0, 6'd63, 8'h00);
    drive_idle();
    repeat (5) drive_idle();

    check_value("drain_a", 32'(sb_a.size()), 32'd0);
    check_value("drain_b", 32'(sb_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sp_clr.md
RAM_SP_CLR -- requirements
Module: ram_sp_clr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, address width; depth DEPTH = 2^ADDR_W.
REQ-003 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 The block SHALL have parameter RW_MODE, default 0; 0 = read-first, 1 = write-first.
REQ-005 The block SHALL have parameter CLR_VAL, default 0, DATA_W-bit fill value used by clear.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 The block SHALL have port clr, input, 1, request to refill the whole memory with CLR_VAL.
REQ-009 The block SHALL have port en, input, 1, access enable.
REQ-010 The block SHALL have port wr, input, 1, write select when en=1 (1 = write, 0 = read).
REQ-011 The block SHALL have port addr, input, ADDR_W, access address.
REQ-012 The block SHALL have port data, input, DATA_W, write data.
REQ-013 The block SHALL have port q, output, DATA_W, registered read data.
REQ-014 The block SHALL have port q_valid, output, 1, one-cycle pulse marking q as new.
REQ-015 The block SHALL have port busy, output, 1, high while clearing; accesses are ignored.

Function
REQ-016 The FSM SHALL have two states, CLEAR and READY; busy=1 exactly when the state is CLEAR.
REQ-017 In CLEAR the block SHALL write CLR_VAL to mem[cnt] each cycle and increment cnt, a counter from 0 to DEPTH-1.
REQ-018 After the write at cnt=DEPTH-1, CLEAR SHALL go to READY, so busy is high for exactly DEPTH cycles.
REQ-019 An access SHALL be accepted only when en=1, busy=0 and clr=0; otherwise memory, q and q_valid are unaffected by en, wr, addr and data.
REQ-020 An accepted write (wr=1) SHALL store data at mem[addr] on that clock edge.
REQ-021 Every accepted access, read or write, SHALL produce a read of addr.
REQ-022 For a write access, the read data SHALL be the old contents when RW_MODE=0 and the new data when RW_MODE=1.
REQ-023 For RD_LAT=1, read data SHALL appear on q with q_valid=1 one cycle after acceptance.
REQ-024 For RD_LAT=2, an extra output register SHALL be added, so q and q_valid appear two cycles after acceptance.
REQ-025 Back-to-back accepted accesses SHALL give one q_valid pulse per access, in order, with no bubbles.
REQ-026 q SHALL hold its last value when q_valid=0.
REQ-027 clr=1 in READY SHALL move the FSM to CLEAR with cnt=0 on the next edge; any access presented in the same cycle is dropped.
REQ-028 clr=1 while in CLEAR SHALL restart the fill from cnt=0.
REQ-029 Reads accepted before a clr SHALL still complete their q/q_valid pipeline with the pre-clear data.
REQ-030 cnt SHALL be ADDR_W bits wide; completion SHALL be detected at cnt=DEPTH-1, not by wrap-around.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force state=CLEAR, cnt=0, busy=1, q=0, q_valid=0, and clear all pipeline valid bits.
REQ-032 Memory contents SHALL NOT be reset asynchronously; the fill starts on the first clk edge after rst_n rises.
REQ-033 Asserting rst_n mid-clear or mid-read SHALL abandon the operation; no stale q_valid pulse SHALL appear after release.

Verification
REQ-034 Reset release with defaults -> busy=1 for 64 cycles then 0; reading addr 0..63 gives q=0x00 with a q_valid pulse one cycle after each read.
REQ-035 Write data 0x01..0x40 to addr 0..63 on consecutive cycles, then read back -> q=addr+1 for every address, 64 contiguous q_valid pulses.
REQ-036 mem[5]=0x55, write 0xAA to addr 5 -> q=0x55 when RW_MODE=0, q=0xAA when RW_MODE=1; a later read of addr 5 gives 0xAA.
REQ-037 One-cycle clr pulse with en=1, wr=1, addr=3, data=0x77 in the same cycle -> write dropped, busy for 64 cycles, then addr 3 reads 0x00; CLR_VAL=0xFF gives 0xFF.
REQ-038 rst_n low for 2 cycles when cnt=20 -> q=0, q_valid=0 immediately; after release busy lasts a full 64 cycles.
REQ-039 RD_LAT=2, reads of addr 1,2,3 on consecutive cycles after loading 0x11,0x22,0x33 -> q_valid high 2 cycles after each read, q = 0x11, 0x22, 0x33 in order.
